// File: rtl/c5_mult.sv
// Multi-cycle multiply/divide unit with HI/LO result registers (shift-add / restoring division).
// Optional feature macro: C5_MULT_DIVIDE_EN enables DIVIDE and SIGNED_DIVIDE.

module c5_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] I_a,
  input  logic [WIDTH-1:0] I_b,
  input  logic             I_cin,
  output logic [WIDTH:0]   O_result
);
  assign O_result = {1'b0, I_a} + {1'b0, I_b} + {{WIDTH{1'b0}}, I_cin};
endmodule

module c5_mult #(
  parameter int WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic [WIDTH-1:0] I_a,
  input  logic [WIDTH-1:0] I_b,
  input  logic [3:0]       I_func,
  output logic [WIDTH-1:0] O_c,
  output logic             O_pause,
  output logic             O_busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [3:0] F_READ_LO = 4'd1, F_READ_HI = 4'd2, F_WRITE_LO = 4'd3,
                         F_WRITE_HI = 4'd4, F_MULT = 4'd5, F_SMULT = 4'd6,
                         F_DIV = 4'd7, F_SDIV = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, op_q, op_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_res;
  logic [2*WIDTH-1:0] prod_neg;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  c5_adder #(.WIDTH(WIDTH)) u_adder (
    .I_a(add_a), .I_b(add_b), .I_cin(add_cin), .O_result(add_res)
  );

`ifdef C5_MULT_DIVIDE_EN
  logic div_q, div_d, rsgn_q, rsgn_d;
  logic no_borrow;
  // Shifted remainder is WIDTH+1 bits; its top bit (hi_q MSB) guarantees no borrow.
  assign add_a     = div_q ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : hi_q;
  assign add_b     = div_q ? ~op_q : (lo_q[0] ? op_q : '0);
  assign add_cin   = div_q;
  assign no_borrow = hi_q[WIDTH-1] | add_res[WIDTH];
`else
  assign add_a   = hi_q;
  assign add_b   = lo_q[0] ? op_q : '0;
  assign add_cin = 1'b0;
`endif

  assign prod_neg = '0 - {hi_q, lo_q};
  assign a_neg    = (I_func == F_SMULT || I_func == F_SDIV) && I_a[WIDTH-1];
  assign b_neg    = (I_func == F_SMULT || I_func == F_SDIV) && I_b[WIDTH-1];
  assign a_mag    = a_neg ? '0 - I_a : I_a;
  assign b_mag    = b_neg ? '0 - I_b : I_b;

  assign O_busy  = (state_q != S_IDLE);
  assign O_pause = (I_func == F_READ_LO || I_func == F_READ_HI) && O_busy;
  assign O_c     = (I_func == F_READ_LO) ? lo_q : (I_func == F_READ_HI) ? hi_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
`ifdef C5_MULT_DIVIDE_EN
    div_d   = div_q;
    rsgn_d  = rsgn_q;
`endif
    case (state_q)
      S_RUN: begin
`ifdef C5_MULT_DIVIDE_EN
        if (div_q) begin
          hi_d = no_borrow ? add_res[WIDTH-1:0] : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          lo_d = {lo_q[WIDTH-2:0], no_borrow};
        end else
`endif
        begin
          hi_d = add_res[WIDTH:1];
          lo_d = {add_res[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
`ifdef C5_MULT_DIVIDE_EN
        if (div_q) begin
          if (sgn_q)  lo_d = '0 - lo_q;
          if (rsgn_q) hi_d = '0 - hi_q;
        end else
`endif
        if (sgn_q) {hi_d, lo_d} = prod_neg;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // Commands override the datapath; any write or start aborts a running op.
    case (I_func)
      F_WRITE_LO: begin lo_d = I_a; hi_d = hi_q; state_d = S_IDLE; cnt_d = '0; end
      F_WRITE_HI: begin hi_d = I_a; lo_d = lo_q; state_d = S_IDLE; cnt_d = '0; end
      F_MULT, F_SMULT: begin
        op_d    = a_mag;
        hi_d    = '0;
        lo_d    = b_mag;
        sgn_d   = a_neg ^ b_neg;
        cnt_d   = CW'(WIDTH);
        state_d = S_RUN;
`ifdef C5_MULT_DIVIDE_EN
        div_d   = 1'b0;
        rsgn_d  = 1'b0;
`endif
      end
`ifdef C5_MULT_DIVIDE_EN
      F_DIV, F_SDIV: begin
        op_d    = b_mag;
        hi_d    = '0;
        lo_d    = a_mag;
        sgn_d   = a_neg ^ b_neg;
        rsgn_d  = a_neg;
        div_d   = 1'b1;
        cnt_d   = CW'(WIDTH);
        state_d = S_RUN;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
`ifdef C5_MULT_DIVIDE_EN
      div_q   <= 1'b0;
      rsgn_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
`ifdef C5_MULT_DIVIDE_EN
      div_q   <= div_d;
      rsgn_q  <= rsgn_d;
`endif
    end
  end
endmodule

// File: tb/tb_c5_mult.sv
// Directed, table-driven bench for c5_mult; divide vectors only when C5_MULT_DIVIDE_EN is defined.

module tb_c5_mult;
  logic        I_clk = 1'b0;
  logic        I_reset;
  logic [31:0] I_a, I_b;
  logic [3:0]  I_func;
  logic [31:0] O_c;
  logic        O_pause, O_busy;

  int total = 0;
  int bad   = 0;

  c5_mult #(.WIDTH(32)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_a(I_a), .I_b(I_b), .I_func(I_func),
    .O_c(O_c), .O_pause(O_pause), .O_busy(O_busy)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    string       name;
    logic [3:0]  func;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at the negedge; each call spans exactly one rising edge.
  task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    I_func = f; I_a = a; I_b = b;
    @(negedge I_clk);
    I_func = 4'd0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge I_clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (O_busy && n < 200) begin n++; @(negedge I_clk); end
  endtask

  task automatic read_chk(input string name, input logic [3:0] f, input logic [31:0] exp);
    I_func = f;
    #1;
    chk({name, "_pause"}, 32'(O_pause), 32'd0);
    chk(name, O_c, exp);
    @(negedge I_clk);
    I_func = 4'd0;
  endtask

  initial begin
    int n;
    I_reset = 1'b1; I_func = 4'd0; I_a = '0; I_b = '0;
    idle_cycles(2);
    I_reset = 1'b0;

    // reset state
    #1;
    chk("rst_busy", 32'(O_busy), 32'd0);
    chk("rst_c_nothing", O_c, 32'd0);
    read_chk("rst_lo", 4'd1, 32'd0);
    read_chk("rst_hi", 4'd2, 32'd0);

    vecs.push_back('{"mul_7x6",      4'd5, 32'd7,        32'd6,        32'd0,        32'd42});
    vecs.push_back('{"mul_max",      4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"smul_m3x5",    4'd6, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{"mul_2p32",     4'd5, 32'h00010000, 32'h00010000, 32'd1,        32'd0});
    vecs.push_back('{"smul_m1xm1",   4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1});
    vecs.push_back('{"smul_min_x2",  4'd6, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'd0});
    vecs.push_back('{"mul_shift",    4'd5, 32'h12345678, 32'h10,       32'd1,        32'h23456780});
`ifdef C5_MULT_DIVIDE_EN
    vecs.push_back('{"sdiv_m7_2",    4'd8, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_100_0",    4'd7, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF});
    vecs.push_back('{"div_100_7",    4'd7, 32'd100,      32'd7,        32'd2,        32'd14});
    vecs.push_back('{"sdiv_7_m2",    4'd8, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD});
    vecs.push_back('{"sdiv_ovf",     4'd8, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000});
    vecs.push_back('{"sdiv_m5_0",    4'd8, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'd1});
    vecs.push_back('{"sdiv_5_0",     4'd8, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF});
    vecs.push_back('{"div_big",      4'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1});
    vecs.push_back('{"div_big2",     4'd7, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1});
`endif

    foreach (vecs[i]) begin
      issue(vecs[i].func, vecs[i].a, vecs[i].b);
      wait_idle(n);
      chk({vecs[i].name, "_lat"}, 32'(n), 32'd33);
      read_chk({vecs[i].name, "_lo"}, 4'd1, vecs[i].lo);
      read_chk({vecs[i].name, "_hi"}, 4'd2, vecs[i].hi);
    end

    // read held while busy: paused until the unit returns to idle
    issue(4'd5, 32'd7, 32'd6);
    idle_cycles(1);
    I_func = 4'd1;
    #1;
    n = 0;
    while (O_pause && n < 100) begin n++; @(negedge I_clk); #1; end
    chk("pause_cycles", 32'(n), 32'd32);
    chk("pause_read_lo", O_c, 32'd42);
    @(negedge I_clk);
    I_func = 4'd0;
    read_chk("pause_read_hi", 4'd2, 32'd0);

    // restart while busy
    issue(4'd5, 32'd1000, 32'd1000);
    idle_cycles(9);
    issue(4'd6, 32'd2, 32'd3);
    wait_idle(n);
    chk("restart_lat", 32'(n), 32'd33);
    read_chk("restart_lo", 4'd1, 32'd6);
    read_chk("restart_hi", 4'd2, 32'd0);

    // reset mid-operation
`ifdef C5_MULT_DIVIDE_EN
    issue(4'd7, 32'd12345, 32'd7);
`else
    issue(4'd5, 32'd12345, 32'd7);
`endif
    idle_cycles(14);
    I_reset = 1'b1;
    @(negedge I_clk);
    I_reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(O_busy), 32'd0);
    read_chk("midrst_lo", 4'd1, 32'd0);
    read_chk("midrst_hi", 4'd2, 32'd0);

    // write while busy aborts the operation
    issue(4'd5, 32'hDEADBEEF, 32'h12345);
    idle_cycles(4);
    issue(4'd4, 32'h1234, 32'd0);
    #1;
    chk("wrbusy_busy", 32'(O_busy), 32'd0);
    read_chk("wrbusy_hi", 4'd2, 32'h1234);
    issue(4'd3, 32'hCAFE0001, 32'd0);
    read_chk("write_lo", 4'd1, 32'hCAFE0001);
    read_chk("write_hi_kept", 4'd2, 32'h1234);

`ifndef C5_MULT_DIVIDE_EN
    // divide commands are inert: no start, no abort
    issue(4'd7, 32'd100, 32'd7);
    #1;
    chk("nodiv_busy", 32'(O_busy), 32'd0);
    read_chk("nodiv_lo", 4'd1, 32'hCAFE0001);
    read_chk("nodiv_hi", 4'd2, 32'h1234);
    issue(4'd5, 32'd9, 32'd11);
    idle_cycles(3);
    issue(4'd8, 32'd1, 32'd1);
    wait_idle(n);
    chk("nodiv_noabort_lat", 32'(n), 32'd29);
    read_chk("nodiv_noabort_lo", 4'd1, 32'd99);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
